br_resolve_q: RTL and testbench
===============================

// Module: br_resolve_q
// PURPOSE
// - Resolution end of the branch predictor: queues in-flight predictions, matches each
//   against the resolved outcome from execute, and drives the update stream (torn + tag)
//   back into the predictor FSM.
// - Flags mispredicts and flushes younger (wrong-path) predictions.
// - Sits between the fetch-side predictor output and the execute-side branch unit.
// PARAMETERS
// - DW     8   width of branch tag (PC slice) carried with each prediction
// - AW     2   queue address width; DEPTH = 1<<AW entries (4)
// - CNT_W  16  width of statistics counters (used only with BR_RES_STATS_EN)
// PORTS
// - clk         in   1      clock; all logic on rising edge
// - reset       in   1      synchronous, active-low reset
// - pred_valid  in   1      prediction issued this cycle
// - pred_taken  in   1      predicted direction (1 = taken)
// - pred_tag    in   DW     tag of the predicted branch
// - pred_ready  out  1      queue can accept a prediction (count < DEPTH), combinational
// - res_valid   in   1      branch resolved this cycle (in program order)
// - res_taken   in   1      actual direction
// - res_tag     in   DW     tag of the resolved branch
// - upd_valid   out  1      one-cycle pulse: update for predictor is valid
// - torn        out  1      actual outcome to predictor FSM (taken or not)
// - upd_data    out  DW     tag of the updated branch (queue head tag)
// - mispredict  out  1      one-cycle pulse: head prediction != actual outcome
// - tag_err     out  1      one-cycle pulse: res_tag != head tag
// - underflow   out  1      one-cycle pulse: res_valid while queue empty
// - stat_res    out  CNT_W  resolved-branch count (stats build only)
// - stat_mis    out  CNT_W  mispredict count (stats build only)
// BEHAVIOUR
// - Reset (reset==0 at posedge): count=0, rd/wr ptrs=0; all outputs 0; pred_ready=1 next.
// - Storage: circular buffer of DEPTH entries {taken, tag}; ptrs wrap modulo DEPTH.
// - Push: pred_valid && pred_ready -> write at wr_ptr, wr_ptr++, count++.
// - Pop: res_valid && count!=0 -> read head; rd_ptr++, count--.
// - Push+pop same cycle with no mispredict: count unchanged; allowed when full?
//   No: pred_ready depends on count only, so full queue rejects pushes that cycle.
// - Outputs registered, latency 1: in the cycle after a pop,
//   upd_valid=1, torn=res_taken, upd_data=head tag,
//   mispredict=(head taken != res_taken), tag_err=(res_tag != head tag).
// - Any cycle without a pop: upd_valid, mispredict, tag_err = 0;
//   torn/upd_data hold last value.
// - Mispredict flush: on a popping cycle where head taken != res_taken, count:=0 and
//   rd_ptr:=wr_ptr after the pop; a simultaneous push is discarded (wrong path).
// - tag_err does not flush; the entry still pops and updates normally.
// - Empty: res_valid -> no pop, underflow=1 next cycle, upd_valid=0, state unchanged.
// - Reset mid-operation: queue contents abandoned; no update pulse is produced.
// CONFIGURATION
// - BR_RES_STATS_EN defined: stat_res += 1 per pop, stat_mis += 1 per mispredict;
//   both saturate at all-ones, cleared by reset, updated with the registered outputs.
// - BR_RES_STATS_EN undefined: no counter registers; stat_res and stat_mis tied to 0.
// TESTING
// - Reset, then 4 pushes (taken=1, tags 0x10..0x13) -> pred_ready=0 after 4th; 5th push
//   ignored; count=4.
// - Resolve 0x10 taken=1 -> next cycle upd_valid=1, torn=1, upd_data=0x10,
//   mispredict=0; pred_ready=1.
// - Resolve 0x11 taken=0 with simultaneous push 0x20 -> mispredict=1, torn=0;
//   queue empty after, 0x20 dropped.
// - Resolve on empty queue -> underflow=1 for one cycle, upd_valid=0.
// - Push 0x30, resolve with tag 0x31 matching direction -> tag_err=1, mispredict=0,
//   queue empties; then wrap: 6 push/pop pairs check ptr wrap and FIFO order.
// - Stats build: 3 pops, 1 mispredict -> stat_res=3, stat_mis=1; pulse reset low
//   mid-queue -> all counters and outputs 0 next cycle.

Source files
------------

// File: rtl/br_resolve_q.sv
// br_resolve_q: branch-resolution queue matching predictions to outcomes and driving predictor updates.
// Optional saturating statistics counters are enabled by defining BR_RES_STATS_EN.
module br_resolve_q #(
    parameter int DW    = 8,
    parameter int AW    = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_valid,
    input  logic             pred_taken,
    input  logic [DW-1:0]    pred_tag,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [DW-1:0]    res_tag,
    output logic             upd_valid,
    output logic             torn,
    output logic [DW-1:0]    upd_data,
    output logic             mispredict,
    output logic             tag_err,
    output logic             underflow,
    output logic [CNT_W-1:0] stat_res,
    output logic [CNT_W-1:0] stat_mis
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [DEPTH-1:0] q_taken;
    logic [DW-1:0]    q_tag [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      count;
    logic             pop, push, mis, head_taken;
    logic [DW-1:0]    head_tag;
    // A mispredicting pop kills any same-cycle push: that prediction is on the wrong path.
    always_comb begin
        pred_ready = count < FULL;
        pop        = res_valid && count != '0;
        head_taken = q_taken[rd_ptr];
        head_tag   = q_tag[rd_ptr];
        mis        = pop && head_taken != res_taken;
        push       = pred_valid && pred_ready && !mis;
    end
    always_ff @(posedge clk) begin
        if (push) begin
            q_taken[wr_ptr] <= pred_taken;
            q_tag[wr_ptr]   <= pred_tag;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            upd_valid  <= 1'b0;
            torn       <= 1'b0;
            upd_data   <= '0;
            mispredict <= 1'b0;
            tag_err    <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            rd_ptr     <= mis ? wr_ptr : rd_ptr + AW'(pop);
            wr_ptr     <= wr_ptr + AW'(push);
            count      <= mis ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
            upd_valid  <= pop;
            mispredict <= mis;
            tag_err    <= pop && res_tag != head_tag;
            underflow  <= res_valid && count == '0;
            if (pop) begin
                torn     <= res_taken;
                upd_data <= head_tag;
            end
        end
    end
`ifdef BR_RES_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_res <= '0;
            stat_mis <= '0;
        end else begin
            if (pop && stat_res != '1) stat_res <= stat_res + CNT_W'(1);
            if (mis && stat_mis != '1) stat_mis <= stat_mis + CNT_W'(1);
        end
    end
`else
    assign stat_res = '0;
    assign stat_mis = '0;
`endif
endmodule

// File: tb/tb_br_resolve_q.sv
// tb_br_resolve_q: directed self-checking bench for br_resolve_q.
module tb_br_resolve_q;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pred_valid = 1'b0, pred_taken = 1'b0;
    logic [7:0]  pred_tag = '0;
    logic        pred_ready;
    logic        res_valid = 1'b0, res_taken = 1'b0;
    logic [7:0]  res_tag = '0;
    logic        upd_valid, torn, mispredict, tag_err, underflow;
    logic [7:0]  upd_data;
    logic [15:0] stat_res, stat_mis;
    int n_cmp = 0, n_bad = 0;

    br_resolve_q dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_tag(pred_tag), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_tag(res_tag),
        .upd_valid(upd_valid), .torn(torn), .upd_data(upd_data),
        .mispredict(mispredict), .tag_err(tag_err), .underflow(underflow),
        .stat_res(stat_res), .stat_mis(stat_mis)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic push(input logic t, input logic [7:0] g);
        pred_valid = 1'b1; pred_taken = t; pred_tag = g;
    endtask

    task automatic resolve(input logic t, input logic [7:0] g);
        res_valid = 1'b1; res_taken = t; res_tag = g;
    endtask

    task automatic test_reset;
        reset = 1'b0; idle();
        tick(); tick();
        n_cmp++; if (upd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_upd_valid got %b want 0", upd_valid); end
        n_cmp++; if (torn !== 1'b0) begin n_bad++; $display("FAIL rst_torn got %b want 0", torn); end
        n_cmp++; if (upd_data !== 8'h00) begin n_bad++; $display("FAIL rst_upd_data got %h want 00", upd_data); end
        n_cmp++; if ({mispredict, tag_err, underflow} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got %b want 000", {mispredict, tag_err, underflow}); end
        n_cmp++; if (pred_ready !== 1'b1) begin n_bad++; $display("FAIL rst_pred_ready got %b want 1", pred_ready); end
        n_cmp++; if ({stat_res, stat_mis} !== 32'h0) begin n_bad++; $display("FAIL rst_stats got %h/%h want 0/0", stat_res, stat_mis); end
        reset = 1'b1;
    endtask

    task automatic test_fill;
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 8'h10 + 8'(i));
            n_cmp++; if (pred_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready_%0d got %b want 1", i, pred_ready); end
            tick();
        end
        n_cmp++; if (pred_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b want 0", pred_ready); end
        push(1'b1, 8'h14);
        tick();
        n_cmp++; if (pred_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_after_5th got %b want 0", pred_ready); end
        n_cmp++; if (upd_valid !== 1'b0) begin n_bad++; $display("FAIL fill_upd_valid got %b want 0", upd_valid); end
        idle();
    endtask

    task automatic test_hit;
        resolve(1'b1, 8'h10);
        tick(); idle();
        n_cmp++; if ({upd_valid, torn, mispredict, tag_err} !== 4'b1100) begin n_bad++; $display("FAIL hit_flags got %b want 1100", {upd_valid, torn, mispredict, tag_err}); end
        n_cmp++; if (upd_data !== 8'h10) begin n_bad++; $display("FAIL hit_upd_data got %h want 10", upd_data); end
        n_cmp++; if (pred_ready !== 1'b1) begin n_bad++; $display("FAIL hit_ready got %b want 1", pred_ready); end
        tick();
        n_cmp++; if ({upd_valid, torn} !== 2'b01) begin n_bad++; $display("FAIL hold_valid_torn got %b want 01", {upd_valid, torn}); end
        n_cmp++; if (upd_data !== 8'h10) begin n_bad++; $display("FAIL hold_upd_data got %h want 10", upd_data); end
    endtask

    task automatic test_mispredict;
        resolve(1'b0, 8'h11);
        push(1'b1, 8'h20);
        tick(); idle();
        n_cmp++; if ({upd_valid, torn, mispredict, tag_err} !== 4'b1010) begin n_bad++; $display("FAIL mis_flags got %b want 1010", {upd_valid, torn, mispredict, tag_err}); end
        n_cmp++; if (upd_data !== 8'h11) begin n_bad++; $display("FAIL mis_upd_data got %h want 11", upd_data); end
        n_cmp++; if (pred_ready !== 1'b1) begin n_bad++; $display("FAIL mis_ready got %b want 1", pred_ready); end
    endtask

    task automatic test_underflow;
        resolve(1'b1, 8'h20);
        tick(); idle();
        n_cmp++; if ({underflow, upd_valid, mispredict} !== 3'b100) begin n_bad++; $display("FAIL uf_flags got %b want 100", {underflow, upd_valid, mispredict}); end
        n_cmp++; if (upd_data !== 8'h11) begin n_bad++; $display("FAIL uf_upd_data got %h want 11", upd_data); end
        tick();
        n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL uf_pulse got %b want 0", underflow); end
    endtask

    task automatic test_tag_err;
        push(1'b0, 8'h30);
        tick(); idle();
        resolve(1'b0, 8'h31);
        tick(); idle();
        n_cmp++; if ({upd_valid, torn, mispredict, tag_err} !== 4'b1001) begin n_bad++; $display("FAIL tagerr_flags got %b want 1001", {upd_valid, torn, mispredict, tag_err}); end
        n_cmp++; if (upd_data !== 8'h30) begin n_bad++; $display("FAIL tagerr_upd_data got %h want 30", upd_data); end
        resolve(1'b0, 8'h30);
        tick(); idle();
        n_cmp++; if ({underflow, upd_valid, tag_err} !== 3'b100) begin n_bad++; $display("FAIL tagerr_empty got %b want 100", {underflow, upd_valid, tag_err}); end
    endtask

    task automatic test_wrap;
        for (int k = 0; k < 12; k++) begin
            int j;
            logic [7:0] tj;
            j = k - 3;
            tj = 8'h40 + 8'(j);
            pred_valid = (k < 9); pred_taken = k[0]; pred_tag = 8'h40 + 8'(k);
            res_valid = (k >= 3); res_taken = j[0]; res_tag = tj;
            tick();
            if (k >= 3) begin
                n_cmp++; if ({upd_valid, torn, mispredict, tag_err} !== {1'b1, j[0], 2'b00}) begin n_bad++; $display("FAIL wrap_flags_%0d got %b want %b", j, {upd_valid, torn, mispredict, tag_err}, {1'b1, j[0], 2'b00}); end
                n_cmp++; if (upd_data !== tj) begin n_bad++; $display("FAIL wrap_data_%0d got %h want %h", j, upd_data, tj); end
            end
        end
        idle();
        resolve(1'b0, 8'h00);
        tick(); idle();
        n_cmp++; if ({underflow, upd_valid} !== 2'b10) begin n_bad++; $display("FAIL wrap_empty got %b want 10", {underflow, upd_valid}); end
    endtask

    task automatic test_flush_multi;
        push(1'b1, 8'h50); tick();
        push(1'b0, 8'h51); tick();
        push(1'b1, 8'h52); tick(); idle();
        resolve(1'b0, 8'h50);
        tick(); idle();
        n_cmp++; if ({upd_valid, mispredict, upd_data} !== {2'b11, 8'h50}) begin n_bad++; $display("FAIL flush_mis got %b/%h want 11/50", {upd_valid, mispredict}, upd_data); end
        resolve(1'b0, 8'h51);
        tick(); idle();
        n_cmp++; if ({underflow, upd_valid} !== 2'b10) begin n_bad++; $display("FAIL flush_empty got %b want 10", {underflow, upd_valid}); end
        push(1'b1, 8'h60); tick(); idle();
        resolve(1'b1, 8'h60);
        tick(); idle();
        n_cmp++; if ({upd_valid, mispredict, tag_err, upd_data} !== {3'b100, 8'h60}) begin n_bad++; $display("FAIL flush_realign got %b/%h want 100/60", {upd_valid, mispredict, tag_err}, upd_data); end
    endtask

    task automatic test_stats_and_reset;
        logic [15:0] want_res, want_mis;
`ifdef BR_RES_STATS_EN
        want_res = 16'd3; want_mis = 16'd1;
`else
        want_res = 16'd0; want_mis = 16'd0;
`endif
        reset = 1'b0; tick(); reset = 1'b1;
        for (int i = 0; i < 3; i++) begin push(1'b1, 8'h70 + 8'(i)); tick(); end
        idle();
        resolve(1'b1, 8'h70); tick();
        resolve(1'b1, 8'h71); tick();
        resolve(1'b0, 8'h72); tick(); idle();
        n_cmp++; if (mispredict !== 1'b1) begin n_bad++; $display("FAIL stats_last_mis got %b want 1", mispredict); end
        n_cmp++; if (stat_res !== want_res) begin n_bad++; $display("FAIL stat_res got %0d want %0d", stat_res, want_res); end
        n_cmp++; if (stat_mis !== want_mis) begin n_bad++; $display("FAIL stat_mis got %0d want %0d", stat_mis, want_mis); end
        push(1'b1, 8'h80); tick();
        push(1'b1, 8'h81); tick(); idle();
        reset = 1'b0;
        resolve(1'b1, 8'h80);
        tick(); idle(); reset = 1'b1;
        n_cmp++; if ({upd_valid, torn, mispredict, tag_err, underflow} !== 5'b00000) begin n_bad++; $display("FAIL midrst_flags got %b want 00000", {upd_valid, torn, mispredict, tag_err, underflow}); end
        n_cmp++; if (upd_data !== 8'h00) begin n_bad++; $display("FAIL midrst_upd_data got %h want 00", upd_data); end
        n_cmp++; if ({stat_res, stat_mis} !== 32'h0) begin n_bad++; $display("FAIL midrst_stats got %h/%h want 0/0", stat_res, stat_mis); end
        n_cmp++; if (pred_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", pred_ready); end
        resolve(1'b1, 8'h80);
        tick(); idle();
        n_cmp++; if ({underflow, upd_valid} !== 2'b10) begin n_bad++; $display("FAIL midrst_abandon got %b want 10", {underflow, upd_valid}); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hit();
        test_mispredict();
        test_underflow();
        test_tag_err();
        test_wrap();
        test_flush_multi();
        test_stats_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
